// File: rtl/lut_neuron_pipe_if.sv
// lut_neuron_pipe_if: lookup, result and table-write channels of a truth-table neuron.
// Ports: in_* lookup request, out_* result, cfg_* table write, init_done.
interface lut_neuron_pipe_if #(
  parameter int FAN_IN   = 4,
  parameter int IN_BITS  = 2,
  parameter int OUT_BITS = 2
);
  localparam int ADDR_W = FAN_IN * IN_BITS;

  logic [ADDR_W-1:0]   in_data;
  logic                in_valid;
  logic                in_ready;
  logic [OUT_BITS-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
  logic                cfg_we;
  logic [ADDR_W-1:0]   cfg_addr;
  logic [OUT_BITS-1:0] cfg_data;
  logic                cfg_ready;
  logic                init_done;

  modport master (
    output in_data, in_valid, out_ready,
    output cfg_we, cfg_addr, cfg_data,
    input  in_ready, out_data, out_valid,
    input  cfg_ready, init_done
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    input  cfg_we, cfg_addr, cfg_data,
    output in_ready, out_data, out_valid,
    output cfg_ready, init_done
  );
endinterface

// File: rtl/lut_neuron_pipe.sv
// lut_neuron_pipe: pipelined, reloadable truth-table neuron (addr reg -> out reg).
// Ports: clk, rst (sync, active-high), bus (slave side of lut_neuron_pipe_if).
module lut_neuron_pipe #(
  parameter int FAN_IN   = 4,
  parameter int IN_BITS  = 2,
  parameter int OUT_BITS = 2
) (
  input logic             clk,
  input logic             rst,
  lut_neuron_pipe_if.slave bus
);
  localparam int ADDR_W = FAN_IN * IN_BITS;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic {INIT, RUN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_q, clr_d;

  logic [OUT_BITS-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0]   a_addr_q, a_addr_d;
  logic                a_valid_q, a_valid_d;
  logic [OUT_BITS-1:0] out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;

  logic                run;
  logic                advance_b;
  logic                in_ready;
  logic                accept;
  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [OUT_BITS-1:0] wdata;

  // FSM and the single table write port (clear in INIT, cfg in RUN)
  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    we      = 1'b0;
    waddr   = clr_q;
    wdata   = '0;
    unique case (state_q)
      INIT: begin
        we    = 1'b1;
        clr_d = clr_q + 1'b1;
        if (clr_q == '1) begin
          state_d = RUN;
        end
      end
      RUN: begin
        we    = bus.cfg_we;
        waddr = bus.cfg_addr;
        wdata = bus.cfg_data;
      end
      default: state_d = INIT;
    endcase
    if (rst) begin
      we = 1'b0;
    end
  end

  assign run       = (state_q == RUN);
  assign advance_b = !out_valid_q || bus.out_ready;
  assign in_ready  = run && (!a_valid_q || advance_b);
  assign accept    = bus.in_valid && in_ready;

  // Stage B reads the table with the pre-edge contents, so a
  // same-cycle write to that address is seen only by later reads.
  always_comb begin
    a_addr_d    = a_addr_q;
    a_valid_d   = a_valid_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (advance_b) begin
      out_data_d  = mem_q[a_addr_q];
      out_valid_d = a_valid_q;
    end
    if (accept) begin
      a_addr_d  = bus.in_data;
      a_valid_d = 1'b1;
    end else if (advance_b) begin
      a_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      clr_q       <= '0;
      a_addr_q    <= '0;
      a_valid_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_q       <= clr_d;
      a_addr_q    <= a_addr_d;
      a_valid_q   <= a_valid_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.cfg_ready = run;
  assign bus.init_done = run;
endmodule
